fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage placed directly downstream of the PC counter. It takes the current PC, issues in-order requests to instruction memory and advances the PC counter through its enable. Returned instructions are buffered, each with its PC, in a small queue and handed to decode through a valid/ready handshake. A redirect flushes all wrong-path state, including responses still in flight.

## Interface
- DEPTH, 4, number of queue entries; power of two, ≥2; also the maximum number of outstanding memory responses.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- pc_in  in  32  current PC from the PC counter.
- pc_en  out  1  enable to the PC counter.
- flush  in  1  redirect; the PC counter loads the redirect target on this same edge.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  response valid; responses arrive in order, at least 1 cycle after acceptance; no backpressure.
- imem_rsp_data  in  32  instruction word.
- id_valid  out  1  instruction available to decode.
- id_instr  out  32  instruction at the queue head.
- id_pc  out  32  PC of the head instruction.
- id_ready  in  1  decode accepts.

## Operation
- Each entry has a state: EMPTY, PENDING (request sent, PC stored) or READY (instruction stored). Entries are allocated and freed in FIFO order using wr/rd pointers and a registered occupancy count `occ` (0..DEPTH).
- `drop_cnt` counts in-flight responses that belong to flushed requests. Range 0..DEPTH.
- imem_req_valid = !rst && !flush && (occ + drop_cnt < DEPTH). imem_req_addr = pc_in.
- Accept (imem_req_valid && imem_req_ready):
  - allocate the entry at wr_ptr as PENDING with pc = pc_in;
  - pc_en = 1, so the PC counter advances.
- pc_en = accept || flush. pc_en = 0 during rst.
- Response with drop_cnt > 0 and no flush: the response is discarded and drop_cnt decrements.
- Response with drop_cnt = 0 and no flush: the data is written into the oldest PENDING entry, which becomes READY.
- A response with no outstanding request is ignored and changes no state.
- id_valid = head entry READY && !flush && !rst. id_instr and id_pc come from the head entry.
- Pop (id_valid && id_ready): the head entry becomes EMPTY, rd_ptr advances and occ decrements.
- Flush:
  - all entries become EMPTY, pointers reset, occ = 0;
  - new drop_cnt = old drop_cnt + PENDING count − imem_rsp_valid;
  - no request is issued and no pop occurs in that cycle.
- Reset:
  - all entries EMPTY with stored pc/instr = 0, pointers 0, occ 0, drop_cnt 0;
  - outputs: id_valid 0, id_instr 0, id_pc 0, imem_req_valid 0, pc_en 0.

## Timing
- The request path is combinational from pc_in, occ and drop_cnt to imem_req_valid and imem_req_addr. pc_en is combinational from imem_req_ready and flush.
- Latency: request accepted at edge t, response at t+k (k ≥ 1), entry READY after the response edge, id_valid at t+k+1. Minimum fetch-to-decode latency is 2 cycles.
- A slot freed by a pop is reusable from the next cycle; occ is registered, so same-cycle reuse does not occur.
- With a 1-cycle memory and id_ready held high, DEPTH ≥ 3 sustains 1 instruction per cycle.
- Simultaneous accept, response and pop in one cycle are all legal and update state independently.
- Flush has priority over accept, response fill and pop.
- imem_req_ready low: pc_en stays 0 and imem_req_addr equals the unchanged pc_in.

## Test plan
- Reset: rst = 1 for 2 cycles with imem_req_ready = 1 -> imem_req_valid = 0, pc_en = 0, id_valid = 0, id_pc = 0. After release, the first request has addr = pc_in = 0x0.
- Streaming: 1-cycle memory, id_ready = 1, PC sequence 0x0, 0x4, 0x8… -> id_valid high from cycle 2 onward, id_pc = 0x0, 0x4, 0x8 in order with matching instr, no bubbles.
- Backpressure: id_ready = 0 -> after 4 accepts, imem_req_valid = 0 and pc_en = 0. Raising id_ready drains 0x0..0xC in order and requests resume one cycle after the first pop.
- Flush with 2 PENDING: memory returns them 3 cycles later -> both discarded. Redirect target 0x100 is the next id_pc; drop_cnt returns to 0.
- Flush coinciding with a response and with id_ready = 1 -> no id transfer, drop_cnt = pending − 1, no request in that cycle.
- Memory stall: imem_req_ready = 0 for 5 cycles -> pc_en = 0, imem_req_addr held at 0x20, queue contents unchanged.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch with a PC-tagged queue between
// the PC counter / instruction memory and decode; redirects drop in-flight work.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_en,
    input  logic        flush,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;
    localparam logic [CW:0] L_DEPTH = (CW + 1)'(DEPTH);

    logic [1:0]    r_state [DEPTH];
    logic [31:0]   r_pc    [DEPTH];
    logic [31:0]   r_instr [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_fp;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_npend;

    logic [CW:0]   w_inflight;
    logic          w_req;
    logic          w_acc;
    logic          w_head_rdy;
    logic          w_pop;
    logic          w_fill;
    logic          w_rsp_drop;
    logic          w_rsp_live;
    logic [CW-1:0] w_flush_drop;

    // r_fp tracks the oldest PENDING entry; responses return in order so it advances like a pointer
    always_comb begin
        w_inflight   = {1'b0, r_occ} + {1'b0, r_drop};
        w_req        = !rst && !flush && (w_inflight < L_DEPTH);
        w_acc        = w_req && imem_req_ready;
        w_head_rdy   = r_state[r_rd] == S_READY;
        w_pop        = !rst && !flush && w_head_rdy && id_ready;
        w_rsp_drop   = imem_rsp_valid && !flush && (r_drop != '0);
        w_fill       = imem_rsp_valid && !flush && (r_drop == '0) && (r_npend != '0);
        w_rsp_live   = imem_rsp_valid && ((r_drop != '0) || (r_npend != '0));
        w_flush_drop = r_drop + r_npend - CW'(w_rsp_live);
    end

    always_comb begin
        imem_req_valid = w_req;
        imem_req_addr  = pc_in;
        pc_en          = !rst && (w_acc || flush);
        id_valid       = !rst && !flush && w_head_rdy;
        id_instr       = rst ? '0 : r_instr[r_rd];
        id_pc          = rst ? '0 : r_pc[r_rd];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_fp    <= '0;
            r_occ   <= '0;
            r_drop  <= '0;
            r_npend <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= S_EMPTY;
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_fp    <= '0;
            r_occ   <= '0;
            r_npend <= '0;
            r_drop  <= w_flush_drop;
            for (int i = 0; i < DEPTH; i++)
                r_state[i] <= S_EMPTY;
        end else begin
            r_wr    <= r_wr + AW'(w_acc);
            r_rd    <= r_rd + AW'(w_pop);
            r_fp    <= r_fp + AW'(w_fill);
            r_occ   <= r_occ + CW'(w_acc) - CW'(w_pop);
            r_npend <= r_npend + CW'(w_acc) - CW'(w_fill);
            r_drop  <= r_drop - CW'(w_rsp_drop);
            if (w_acc) begin
                r_state[r_wr] <= S_PEND;
                r_pc[r_wr]    <= pc_in;
            end
            if (w_fill) begin
                r_state[r_fp] <= S_READY;
                r_instr[r_fp] <= imem_rsp_data;
            end
            if (w_pop)
                r_state[r_rd] <= S_EMPTY;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench with a PC counter, in-order memory and a queue-level reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        imem_req_ready = 1'b1;
    logic        id_ready = 1'b0;
    logic        spur = 1'b0;
    logic [31:0] spur_d = 32'h0;
    logic [31:0] pc_in = 32'h0;
    logic [31:0] tgt = 32'h0;
    logic        mem_v = 1'b0;
    logic [31:0] mem_d = 32'h0;
    logic        pc_en;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    int total = 0;
    int bad = 0;
    int lat = 1;
    int cyc = 0;
    int last_due = 0;

    assign imem_rsp_valid = mem_v | spur;
    assign imem_rsp_data  = spur ? spur_d : mem_d;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en), .flush(flush),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", n, act, exp, $time);
        end
    endfunction

    function automatic int next_due(int c, int l, int ld);
        return (c + l > ld) ? c + l : ld + 1;
    endfunction

    // PC counter: redirect target on flush, +4 on enable
    always @(posedge clk)
        pc_in <= rst ? 32'h0 : flush ? tgt : pc_en ? pc_in + 32'h4 : pc_in;

    // In-order memory: response sampled at edge 'due', at least lat edges after acceptance
    typedef struct { logic [31:0] a; int due; } mreq_t;
    mreq_t mq[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            mq.delete();
            mem_v <= 1'b0;
            last_due <= 0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_req_addr, next_due(cyc, lat, last_due)});
                last_due <= next_due(cyc, lat, last_due);
            end
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                mem_v <= 1'b1;
                mem_d <= f(mq[0].a);
                void'(mq.pop_front());
            end else
                mem_v <= 1'b0;
        end
    end

    // Reference model: ordered list of live fetches plus count of responses owed to flushed fetches
    typedef struct { logic [31:0] pc; logic [31:0] ins; bit rdy; } ent_t;
    ent_t mdl[$];
    int m_drop = 0;
    always @(negedge clk) begin : cmp
        bit e_rv, e_idv, acc, pop, done;
        int np;
        ent_t e;
        #2;
        e_rv  = !rst && !flush && (mdl.size() + m_drop < DEPTH);
        e_idv = !rst && !flush && mdl.size() > 0 && mdl[0].rdy;
        acc   = e_rv && imem_req_ready;
        pop   = e_idv && id_ready;
        chk("m_req_valid", {31'h0, imem_req_valid}, {31'h0, e_rv});
        chk("m_req_addr", imem_req_addr, pc_in);
        chk("m_pc_en", {31'h0, pc_en}, {31'h0, !rst && (acc || flush)});
        chk("m_id_valid", {31'h0, id_valid}, {31'h0, e_idv});
        if (e_idv) begin
            chk("m_id_pc", id_pc, mdl[0].pc);
            chk("m_id_instr", id_instr, mdl[0].ins);
        end
        if (rst) begin
            chk("m_rst_id_pc", id_pc, 32'h0);
            chk("m_rst_id_instr", id_instr, 32'h0);
            mdl.delete();
            m_drop = 0;
        end else if (flush) begin
            np = 0;
            for (int i = 0; i < mdl.size(); i++)
                if (!mdl[i].rdy) np++;
            m_drop = m_drop + np - ((imem_rsp_valid && (m_drop + np > 0)) ? 1 : 0);
            mdl.delete();
        end else begin
            if (imem_rsp_valid) begin
                if (m_drop > 0) m_drop--;
                else begin
                    done = 0;
                    for (int i = 0; i < mdl.size(); i++)
                        if (!done && !mdl[i].rdy) begin
                            e = mdl[i];
                            e.rdy = 1;
                            e.ins = imem_rsp_data;
                            mdl[i] = e;
                            done = 1;
                        end
                end
            end
            if (pop) void'(mdl.pop_front());
            if (acc) mdl.push_back('{pc_in, 32'h0, 1'b0});
        end
    end

    task automatic do_reset(int l);
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; spur = 1'b0; id_ready = 1'b0; imem_req_ready = 1'b1; lat = l;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // reset values
        @(negedge clk); #3;
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_pc_en", {31'h0, pc_en}, 32'h0);
        chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);

        // streaming with a 1-cycle memory
        do_reset(1); id_ready = 1'b1; #3;
        chk("str_addr0", imem_req_addr, 32'h0);
        chk("str_rv0", {31'h0, imem_req_valid}, 32'h1);
        @(negedge clk); #3;
        chk("str_addr1", imem_req_addr, 32'h4);
        chk("str_idv1", {31'h0, id_valid}, 32'h0);
        @(negedge clk); #3;
        chk("str_ins0", id_instr, 32'hFFFF_0000);
        @(negedge clk); #3;
        chk("str_ins1", id_instr, 32'hFFFB_0004);
        for (int k = 2; k < 8; k++) begin
            @(negedge clk); #3;
            chk("str_idv", {31'h0, id_valid}, 32'h1);
            chk("str_pc", id_pc, 4 * k);
        end

        // backpressure
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #3;
            chk("bp_en", {31'h0, pc_en}, 32'h1);
            chk("bp_addr", imem_req_addr, 4 * k);
        end
        @(negedge clk); #3;
        chk("bp_full_rv", {31'h0, imem_req_valid}, 32'h0);
        chk("bp_full_en", {31'h0, pc_en}, 32'h0);
        chk("bp_full_addr", imem_req_addr, 32'h10);
        @(negedge clk); id_ready = 1'b1; #3;
        chk("bp_rv_at_pop", {31'h0, imem_req_valid}, 32'h0);
        chk("bp_pc0", id_pc, 32'h0);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk); #3;
            chk("bp_idv", {31'h0, id_valid}, 32'h1);
            chk("bp_pc", id_pc, 4 * k);
            if (k == 1) chk("bp_resume", {31'h0, imem_req_valid}, 32'h1);
        end

        // flush with two pending, 3-cycle memory
        do_reset(3); id_ready = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b1; tgt = 32'h100; #3;
        chk("fl_rv", {31'h0, imem_req_valid}, 32'h0);
        chk("fl_en", {31'h0, pc_en}, 32'h1);
        chk("fl_idv", {31'h0, id_valid}, 32'h0);
        @(negedge clk); flush = 1'b0; #3;
        chk("fl_drop2", 32'(dut.r_drop), 32'h2);
        chk("fl_addr", imem_req_addr, 32'h100);
        repeat (4) @(negedge clk); #3;
        chk("fl_idv_tgt", {31'h0, id_valid}, 32'h1);
        chk("fl_pc100", id_pc, 32'h100);
        chk("fl_drop0", 32'(dut.r_drop), 32'h0);
        @(negedge clk); #3;
        chk("fl_pc104", id_pc, 32'h104);

        // flush together with a response and a ready head
        do_reset(2); id_ready = 1'b1;
        repeat (3) @(negedge clk);
        flush = 1'b1; tgt = 32'h200; #3;
        chk("fx_idv", {31'h0, id_valid}, 32'h0);
        chk("fx_rv", {31'h0, imem_req_valid}, 32'h0);
        @(negedge clk); flush = 1'b0; #3;
        chk("fx_drop1", 32'(dut.r_drop), 32'h1);
        @(negedge clk); #3;
        chk("fx_drop0", 32'(dut.r_drop), 32'h0);
        repeat (2) @(negedge clk); #3;
        chk("fx_pc200", id_pc, 32'h200);
        chk("fx_idv200", {31'h0, id_valid}, 32'h1);

        // memory stall with a parked queue
        do_reset(1); id_ready = 1'b1;
        repeat (8) @(negedge clk);
        id_ready = 1'b0; imem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #3;
            chk("st_en", {31'h0, pc_en}, 32'h0);
            chk("st_addr", imem_req_addr, 32'h20);
            chk("st_pc", id_pc, 32'h18);
        end
        @(negedge clk); id_ready = 1'b1; imem_req_ready = 1'b1; #3;
        chk("st_resume_en", {31'h0, pc_en}, 32'h1);
        chk("st_resume_pc", id_pc, 32'h18);
        @(negedge clk); #3;
        chk("st_pc1c", id_pc, 32'h1C);
        @(negedge clk); #3;
        chk("st_pc20", id_pc, 32'h20);

        // response with nothing outstanding
        do_reset(1); imem_req_ready = 1'b0; spur = 1'b1; spur_d = 32'hBAD0_BAD0; #3;
        chk("sp_rv", {31'h0, imem_req_valid}, 32'h1);
        @(negedge clk); spur = 1'b0; imem_req_ready = 1'b1; #3;
        chk("sp_drop", 32'(dut.r_drop), 32'h0);
        chk("sp_idv", {31'h0, id_valid}, 32'h0);
        @(negedge clk); #3;
        chk("sp_idv2", {31'h0, id_valid}, 32'h0);
        @(negedge clk); #3;
        chk("sp_ins", id_instr, 32'hFFFF_0000);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
